// File: rtl/dst40_pkg.sv
// Shared types and constants for the DST40 key-search job controller.
package dst40_pkg;

   localparam int unsigned KEY_W      = 40;
   localparam int unsigned CHAL_W     = 40;
   localparam int unsigned RESP_W     = 24;
   localparam int unsigned CYC_W      = 48;
   localparam int unsigned STAT_W     = 2;
   // Engine run synchroniser (2 flops) plus key reload
   localparam int unsigned LOAD_LEN   = 4;
   localparam int unsigned LOAD_CNT_W = $clog2(LOAD_LEN);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_RUN  = 2'd2,
      S_DONE = 2'd3
   } state_e;

   typedef logic [STAT_W-1:0] status_t;

   localparam status_t STAT_NONE      = 2'd0;
   localparam status_t STAT_FOUND     = 2'd1;
   localparam status_t STAT_NOT_FOUND = 2'd2;
   localparam status_t STAT_ABORTED   = 2'd3;

   // Job payload handed to the engine
   typedef struct packed {
      logic [CHAL_W-1:0] challenge;
      logic [RESP_W-1:0] response;
      logic [KEY_W-1:0]  start_key;
   } job_t;

   // Saturating increment of the RUN-cycle counter
   function automatic logic [CYC_W-1:0] cyc_sat_inc(input logic [CYC_W-1:0] v);
      return (&v) ? v : v + CYC_W'(1);
   endfunction

endpackage

// File: rtl/dst40_prio_enc.sv
// Lowest-set-bit encoder over the kernel match vector, plus multi-hit flag.
module dst40_prio_enc #(
   parameter int unsigned NK   = 2,
   parameter int unsigned L2NK = 1
) (
   input  logic [NK-1:0]   req_i,
   output logic [L2NK-1:0] idx_o,
   output logic            multi_o
);

   // Scan from the top so the lowest set bit wins
   always_comb begin
      idx_o = '0;
      for (int i = NK - 1; i >= 0; i--) begin
         if (req_i[i]) idx_o = L2NK'(i);
      end
   end

   // Clearing the lowest set bit leaves something only when two or more bits are set
   assign multi_o = |(req_i & (req_i - NK'(1)));

endmodule

// File: rtl/dst40_job_ctrl.sv
// Job controller for the DST40 key-search engine: accepts a job, sequences
// the engine through load/run, and reports the outcome with a cycle count.
module dst40_job_ctrl
   import dst40_pkg::*;
#(
   parameter int unsigned NK   = 2,
   parameter int unsigned L2NK = 1
) (
   input  logic                  clock_i,
   input  logic                  reset_i,
   input  logic                  job_valid_i,
   output logic                  job_ready_o,
   input  logic [CHAL_W-1:0]     job_challenge_i,
   input  logic [RESP_W-1:0]     job_response_i,
   input  logic [KEY_W-1:0]      job_start_key_i,
   input  logic                  abort_i,
   output logic                  busy_o,
   output logic                  res_valid_o,
   input  logic                  res_ready_i,
   output logic [STAT_W-1:0]     res_status_o,
   output logic [KEY_W-1:0]      res_key_o,
   output logic                  res_multi_o,
   output logic [CYC_W-1:0]      res_cycles_o,
   output logic [CHAL_W-1:0]     eng_challenge_o,
   output logic [RESP_W-1:0]     eng_response_o,
   output logic [KEY_W-1:0]      eng_start_key_o,
   output logic                  eng_run_o,
   input  logic                  eng_key_found_i,
   input  logic                  eng_key_not_found_i,
   input  logic [NK-1:0]         eng_kernels_i,
   input  logic [KEY_W-L2NK-1:0] eng_key_i
);

   state_e                state_q;
   logic [LOAD_CNT_W-1:0] load_cnt_q;
   logic [CYC_W-1:0]      cycles_q;
   job_t                  job_q;
   logic [L2NK-1:0]       hit_idx;
   logic                  hit_multi;

   dst40_prio_enc #(
      .NK   (NK),
      .L2NK (L2NK)
   ) u_prio_enc (
      .req_i   (eng_kernels_i),
      .idx_o   (hit_idx),
      .multi_o (hit_multi)
   );

   assign eng_challenge_o = job_q.challenge;
   assign eng_response_o  = job_q.response;
   assign eng_start_key_o = job_q.start_key;
   assign res_cycles_o    = cycles_q;

   // Job sequencer; every output changes only on the clock edge
   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         state_q      <= S_IDLE;
         load_cnt_q   <= '0;
         cycles_q     <= '0;
         job_q        <= '0;
         job_ready_o  <= 1'b1;
         busy_o       <= 1'b0;
         eng_run_o    <= 1'b0;
         res_valid_o  <= 1'b0;
         res_status_o <= STAT_NONE;
         res_key_o    <= '0;
         res_multi_o  <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (job_valid_i) begin
                  job_q.challenge <= job_challenge_i;
                  job_q.response  <= job_response_i;
                  job_q.start_key <= job_start_key_i;
                  cycles_q        <= '0;
                  load_cnt_q      <= '0;
                  job_ready_o     <= 1'b0;
                  busy_o          <= 1'b1;
                  state_q         <= S_LOAD;
               end
            end
            S_LOAD: begin
               if (abort_i) begin
                  res_status_o <= STAT_ABORTED;
                  res_key_o    <= '0;
                  res_multi_o  <= 1'b0;
                  res_valid_o  <= 1'b1;
                  busy_o       <= 1'b0;
                  state_q      <= S_DONE;
               end else if (load_cnt_q == LOAD_CNT_W'(LOAD_LEN - 1)) begin
                  eng_run_o <= 1'b1;
                  state_q   <= S_RUN;
               end else begin
                  load_cnt_q <= load_cnt_q + LOAD_CNT_W'(1);
               end
            end
            S_RUN: begin
               cycles_q <= cyc_sat_inc(cycles_q);
               if (eng_key_found_i || eng_key_not_found_i || abort_i) begin
                  eng_run_o   <= 1'b0;
                  busy_o      <= 1'b0;
                  res_valid_o <= 1'b1;
                  state_q     <= S_DONE;
               end
               if (eng_key_found_i) begin
                  res_status_o <= STAT_FOUND;
                  res_key_o    <= {hit_idx, eng_key_i};
                  res_multi_o  <= hit_multi;
               end else if (eng_key_not_found_i) begin
                  res_status_o <= STAT_NOT_FOUND;
                  res_key_o    <= '0;
                  res_multi_o  <= 1'b0;
               end else if (abort_i) begin
                  res_status_o <= STAT_ABORTED;
                  res_key_o    <= '0;
                  res_multi_o  <= 1'b0;
               end
            end
            S_DONE: begin
               if (res_ready_i) begin
                  res_valid_o <= 1'b0;
                  job_ready_o <= 1'b1;
                  state_q     <= S_IDLE;
               end
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dst40_job_ctrl.sv
// Self-checking bench for dst40_job_ctrl with a behavioural engine model.
module tb_dst40_job_ctrl;

   localparam int NK   = 2;
   localparam int L2NK = 1;

   localparam logic [1:0] E_FOUND     = 2'd1;
   localparam logic [1:0] E_NOT_FOUND = 2'd2;
   localparam logic [1:0] E_ABORTED   = 2'd3;

   logic        clock_i = 1'b0;
   logic        reset_i = 1'b1;
   logic        job_valid_i = 1'b0;
   logic        job_ready_o;
   logic [39:0] job_challenge_i = '0;
   logic [23:0] job_response_i = '0;
   logic [39:0] job_start_key_i = '0;
   logic        abort_i = 1'b0;
   logic        busy_o;
   logic        res_valid_o;
   logic        res_ready_i = 1'b1;
   logic [1:0]  res_status_o;
   logic [39:0] res_key_o;
   logic        res_multi_o;
   logic [47:0] res_cycles_o;
   logic [39:0] eng_challenge_o;
   logic [23:0] eng_response_o;
   logic [39:0] eng_start_key_o;
   logic        eng_run_o;
   logic        eng_key_found_i = 1'b0;
   logic        eng_key_not_found_i = 1'b0;
   logic [NK-1:0]       eng_kernels_i = '0;
   logic [40-L2NK-1:0]  eng_key_i = '0;

   typedef struct packed {
      logic [1:0]  status;
      logic [39:0] key;
      logic        multi;
      logic [47:0] cycles;
   } exp_t;

   exp_t sb_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   dst40_job_ctrl #(.NK(NK), .L2NK(L2NK)) dut (
      .clock_i             (clock_i),
      .reset_i             (reset_i),
      .job_valid_i         (job_valid_i),
      .job_ready_o         (job_ready_o),
      .job_challenge_i     (job_challenge_i),
      .job_response_i      (job_response_i),
      .job_start_key_i     (job_start_key_i),
      .abort_i             (abort_i),
      .busy_o              (busy_o),
      .res_valid_o         (res_valid_o),
      .res_ready_i         (res_ready_i),
      .res_status_o        (res_status_o),
      .res_key_o           (res_key_o),
      .res_multi_o         (res_multi_o),
      .res_cycles_o        (res_cycles_o),
      .eng_challenge_o     (eng_challenge_o),
      .eng_response_o      (eng_response_o),
      .eng_start_key_o     (eng_start_key_o),
      .eng_run_o           (eng_run_o),
      .eng_key_found_i     (eng_key_found_i),
      .eng_key_not_found_i (eng_key_not_found_i),
      .eng_kernels_i       (eng_kernels_i),
      .eng_key_i           (eng_key_i)
   );

   always #5 clock_i = ~clock_i;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clock_i);
      #1;
   endtask

   // Offer a job and wait for it to be taken; checks the engine-side capture
   task automatic start_job(input logic [39:0] ch, input logic [23:0] rs, input logic [39:0] sk);
      int   budget = 0;
      logic taken  = 1'b0;
      job_valid_i = 1'b1; job_challenge_i = ch; job_response_i = rs; job_start_key_i = sk;
      while (!taken && budget < 50) begin
         taken = job_ready_o;
         tick();
         budget++;
      end
      job_valid_i = 1'b0;
      n_tests++;
      if (!taken) begin n_fail++; $display("FAIL accept_timeout: job_ready_o never high"); end
      n_tests++;
      if (eng_challenge_o !== ch || eng_response_o !== rs || eng_start_key_o !== sk) begin
         n_fail++;
         $display("FAIL eng_capture: got ch=%h rs=%h sk=%h want ch=%h rs=%h sk=%h",
                  eng_challenge_o, eng_response_o, eng_start_key_o, ch, rs, sk);
      end
      n_tests++;
      if (busy_o !== 1'b1 || job_ready_o !== 1'b0) begin
         n_fail++;
         $display("FAIL accept_state: busy=%b job_ready=%b want busy=1 job_ready=0", busy_o, job_ready_o);
      end
   endtask

   // Count LOAD cycles (eng_run_o low while busy) until the engine is started
   task automatic wait_load();
      int n = 0;
      while (eng_run_o !== 1'b1 && n < 20) begin
         n++;
         tick();
      end
      n_tests++;
      if (n != 4) begin n_fail++; $display("FAIL load_len: got %0d cycles want 4", n); end
   endtask

   // Engine model: raise the given flags during RUN cycle n, then wait for DONE
   task automatic run_until(input int n, input logic f, input logic nf, input logic ab,
                            input logic [NK-1:0] kern, input logic [40-L2NK-1:0] key);
      int rc = 0;
      int budget = 0;
      while (res_valid_o !== 1'b1 && budget < 2000) begin
         if (eng_run_o === 1'b1) begin
            rc++;
            if (rc == n) begin
               eng_key_found_i = f; eng_key_not_found_i = nf; abort_i = ab;
               eng_kernels_i = kern; eng_key_i = key;
            end
         end
         tick();
         eng_key_found_i = 1'b0; eng_key_not_found_i = 1'b0; abort_i = 1'b0;
         eng_kernels_i = '0; eng_key_i = '0;
         budget++;
      end
      n_tests++;
      if (res_valid_o !== 1'b1) begin n_fail++; $display("FAIL run_timeout: res_valid_o never high"); end
      n_tests++;
      if (eng_run_o !== 1'b0 || busy_o !== 1'b0) begin
         n_fail++;
         $display("FAIL done_entry: eng_run=%b busy=%b want 0 0", eng_run_o, busy_o);
      end
   endtask

   // Pop the expected result, compare, then complete the handshake
   task automatic collect(input string name);
      int   budget = 0;
      exp_t e;
      while (res_valid_o !== 1'b1 && budget < 100) begin tick(); budget++; end
      n_tests++;
      if (sb_q.size() == 0) begin
         n_fail++; $display("FAIL %s_sb_empty: result with no expectation", name);
      end else if (res_valid_o !== 1'b1) begin
         n_fail++; $display("FAIL %s_no_result: res_valid_o stayed low", name);
         void'(sb_q.pop_front());
      end else begin
         e = sb_q.pop_front();
         if (res_status_o !== e.status || res_key_o !== e.key || res_multi_o !== e.multi ||
             res_cycles_o !== e.cycles) begin
            n_fail++;
            $display("FAIL %s_result: got st=%0d key=%h multi=%b cyc=%0d want st=%0d key=%h multi=%b cyc=%0d",
                     name, res_status_o, res_key_o, res_multi_o, res_cycles_o,
                     e.status, e.key, e.multi, e.cycles);
         end
      end
      res_ready_i = 1'b1;
      tick();
      n_tests++;
      if (res_valid_o !== 1'b0 || job_ready_o !== 1'b1) begin
         n_fail++;
         $display("FAIL %s_handshake: res_valid=%b job_ready=%b want 0 1", name, res_valid_o, job_ready_o);
      end
   endtask

   task automatic check_reset_outputs(input string name);
      n_tests++;
      if (job_ready_o !== 1'b1 || busy_o !== 1'b0 || eng_run_o !== 1'b0 || res_valid_o !== 1'b0 ||
          res_status_o !== 2'd0 || res_key_o !== 40'd0 || res_multi_o !== 1'b0 ||
          res_cycles_o !== 48'd0 || eng_challenge_o !== 40'd0 || eng_response_o !== 24'd0 ||
          eng_start_key_o !== 40'd0) begin
         n_fail++;
         $display("FAIL %s: rdy=%b busy=%b run=%b vld=%b st=%0d key=%h multi=%b cyc=%0d ch=%h want rdy=1 rest 0",
                  name, job_ready_o, busy_o, eng_run_o, res_valid_o, res_status_o, res_key_o,
                  res_multi_o, res_cycles_o, eng_challenge_o);
      end
   endtask

   task automatic test_reset();
      reset_i = 1'b1;
      tick(); tick();
      check_reset_outputs("reset_state");
      reset_i = 1'b0;
      // abort in IDLE must not start anything
      abort_i = 1'b1;
      tick();
      abort_i = 1'b0;
      tick();
      n_tests++;
      if (job_ready_o !== 1'b1 || res_valid_o !== 1'b0 || busy_o !== 1'b0) begin
         n_fail++;
         $display("FAIL idle_abort: rdy=%b vld=%b busy=%b want 1 0 0", job_ready_o, res_valid_o, busy_o);
      end
   endtask

   task automatic test_found();
      sb_q.push_back('{E_FOUND, 40'h92_3456_789A, 1'b0, 48'd100});
      start_job(40'h11_2233_4455, 24'hABCDEF, 40'h00_0000_0000);
      wait_load();
      run_until(100, 1'b1, 1'b0, 1'b0, 2'b10, 39'h12_3456_789A);
      collect("found_k1");
      // eng_* stay put after the result is consumed
      n_tests++;
      if (eng_challenge_o !== 40'h11_2233_4455 || eng_response_o !== 24'hABCDEF) begin
         n_fail++;
         $display("FAIL eng_hold_idle: ch=%h rs=%h want 1122334455 abcdef", eng_challenge_o, eng_response_o);
      end
      sb_q.push_back('{E_FOUND, 40'h00_0000_0005, 1'b1, 48'd3});
      start_job(40'hAA_0000_0001, 24'h000102, 40'h01_0000_0000);
      wait_load();
      run_until(3, 1'b1, 1'b0, 1'b0, 2'b11, 39'h00_0000_0005);
      collect("found_multi");
      sb_q.push_back('{E_FOUND, 40'h7F_FFFF_FFFF, 1'b0, 48'd1});
      start_job(40'h55_5555_5555, 24'h555555, 40'h00_0000_0010);
      wait_load();
      run_until(1, 1'b1, 1'b0, 1'b0, 2'b01, 39'h7F_FFFF_FFFF);
      collect("found_k0");
   endtask

   task automatic test_not_found();
      sb_q.push_back('{E_NOT_FOUND, 40'd0, 1'b0, 48'd7});
      start_job(40'h0F_0F0F_0F0F, 24'h123456, 40'h00_0000_0000);
      wait_load();
      run_until(7, 1'b0, 1'b1, 1'b0, 2'b11, 39'h12_3456_789A);
      collect("not_found");
   endtask

   task automatic test_priority();
      sb_q.push_back('{E_FOUND, 40'h80_0000_0042, 1'b0, 48'd5});
      start_job(40'h01_0203_0405, 24'h060708, 40'h00_0000_0000);
      wait_load();
      run_until(5, 1'b1, 1'b0, 1'b1, 2'b10, 39'h00_0000_0042);
      collect("found_over_abort");
      sb_q.push_back('{E_FOUND, 40'h00_0000_0099, 1'b1, 48'd2});
      start_job(40'h01_0203_0406, 24'h060709, 40'h00_0000_0000);
      wait_load();
      run_until(2, 1'b1, 1'b1, 1'b1, 2'b11, 39'h00_0000_0099);
      collect("found_over_nf");
      sb_q.push_back('{E_NOT_FOUND, 40'd0, 1'b0, 48'd4});
      start_job(40'h01_0203_0407, 24'h06070A, 40'h00_0000_0000);
      wait_load();
      run_until(4, 1'b0, 1'b1, 1'b1, 2'b01, 39'h00_0000_0001);
      collect("nf_over_abort");
   endtask

   task automatic test_abort();
      logic rose = 1'b0;
      sb_q.push_back('{E_ABORTED, 40'd0, 1'b0, 48'd0});
      start_job(40'hDE_ADBE_EF00, 24'hC0FFEE, 40'h00_0000_0000);
      rose |= eng_run_o;
      tick();                      // now in LOAD cycle 2
      rose |= eng_run_o;
      abort_i = 1'b1;
      tick();
      abort_i = 1'b0;
      for (int i = 0; i < 6; i++) begin
         rose |= eng_run_o;
         if (i < 5 && res_valid_o !== 1'b1) tick();
      end
      n_tests++;
      if (rose !== 1'b0) begin n_fail++; $display("FAIL abort_load_run: eng_run_o rose=%b want 0", rose); end
      collect("abort_load");
      sb_q.push_back('{E_ABORTED, 40'd0, 1'b0, 48'd10});
      start_job(40'hDE_ADBE_EF01, 24'hC0FFEF, 40'h00_0000_0000);
      wait_load();
      run_until(10, 1'b0, 1'b0, 1'b1, 2'b11, 39'h00_0000_0777);
      collect("abort_run");
   endtask

   task automatic test_back_to_back();
      logic [1:0]  st0;
      logic [39:0] key0;
      logic [47:0] cyc0;
      int          bad = 0;
      res_ready_i = 1'b0;
      sb_q.push_back('{E_FOUND, 40'h80_0000_1234, 1'b0, 48'd4});
      start_job(40'h12_1212_1212, 24'h343434, 40'h00_0000_0000);
      wait_load();
      run_until(4, 1'b1, 1'b0, 1'b0, 2'b10, 39'h00_0000_1234);
      st0 = res_status_o; key0 = res_key_o; cyc0 = res_cycles_o;
      job_valid_i = 1'b1; job_challenge_i = 40'h34_3434_3434;
      job_response_i = 24'h565656; job_start_key_i = 40'h00_0000_0100;
      // late engine flags after capture are ignored
      eng_key_found_i = 1'b1; eng_kernels_i = 2'b11; eng_key_i = 39'h00_0000_00FF;
      for (int i = 0; i < 10; i++) begin
         tick();
         eng_key_found_i = 1'b0; eng_kernels_i = '0; eng_key_i = '0;
         if (res_valid_o !== 1'b1 || job_ready_o !== 1'b0 || res_status_o !== st0 ||
             res_key_o !== key0 || res_cycles_o !== cyc0 || eng_challenge_o !== 40'h12_1212_1212)
            bad++;
      end
      n_tests++;
      if (bad != 0) begin
         n_fail++;
         $display("FAIL hold_done: %0d unstable cycles, vld=%b rdy=%b key=%h want 0", bad, res_valid_o, job_ready_o, res_key_o);
      end
      collect("backpressure");
      tick();
      job_valid_i = 1'b0;
      n_tests++;
      if (busy_o !== 1'b1 || eng_challenge_o !== 40'h34_3434_3434 || eng_start_key_o !== 40'h00_0000_0100) begin
         n_fail++;
         $display("FAIL b2b_accept: busy=%b ch=%h sk=%h want 1 3434343434 0000000100", busy_o, eng_challenge_o, eng_start_key_o);
      end
      sb_q.push_back('{E_ABORTED, 40'd0, 1'b0, 48'd2});
      wait_load();
      run_until(2, 1'b0, 1'b0, 1'b1, 2'b00, 39'd0);
      collect("b2b_second");
   endtask

   task automatic test_reset_mid_run();
      int seen = 0;
      start_job(40'h99_8877_6655, 24'h443322, 40'h00_0000_0000);
      wait_load();
      for (int i = 0; i < 5; i++) tick();
      reset_i = 1'b1;
      tick();
      reset_i = 1'b0;
      check_reset_outputs("reset_mid_run");
      for (int i = 0; i < 20; i++) begin
         if (res_valid_o !== 1'b0 || eng_run_o !== 1'b0) seen++;
         tick();
      end
      n_tests++;
      if (seen != 0) begin n_fail++; $display("FAIL reset_no_result: %0d active cycles want 0", seen); end
   endtask

   initial begin
      test_reset();
      test_found();
      test_not_found();
      test_priority();
      test_abort();
      test_back_to_back();
      test_reset_mid_run();
      n_tests++;
      if (sb_q.size() != 0) begin n_fail++; $display("FAIL sb_leftover: %0d want 0", sb_q.size()); end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
